// File: rtl/tiny_host_seq.sv
// Host-side sequencer for the tiny pairing core: loads four operands, runs the core, streams back ten results.
// Optional RUN watchdog enabled by defining TINY_SEQ_TIMEOUT_EN (TIMEOUT parameter exists only then).
module tiny_host_seq #(
   parameter int W      = 198,
   parameter int RD_LAT = 1
`ifdef TINY_SEQ_TIMEOUT_EN
   ,
   parameter int TIMEOUT = 4096
`endif
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] xp,
   input  logic [W-1:0] yp,
   input  logic [W-1:0] xq,
   input  logic [W-1:0] yq,
   output logic         busy,
   output logic         err,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [5:0]   res_addr,
   output logic [W-1:0] res_data,
   output logic         res_last,
   output logic         t_reset,
   output logic         t_sel,
   output logic         t_w,
   output logic [5:0]   t_addr,
   output logic [W-1:0] t_data,
   input  logic [W-1:0] t_out,
   input  logic         t_done
);

   typedef enum logic [2:0] {IDLE, LOAD, RUN, READ, PUSH} state_t;

   localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [LW-1:0] LAT_LAST = LW'(RD_LAT - 1);

   state_t         state_q;
   logic [3:0]     idx_q;
   logic [LW-1:0]  lat_q;
   logic           doneSeen_q;
   logic [W-1:0]   op1_q, op2_q, op3_q;
   logic           busy_q, resValid_q, resLast_q;
   logic [5:0]     resAddr_q, tAddr_q;
   logic [W-1:0]   resData_q, tData_q;
   logic           tReset_q, tSel_q, tW_q;

`ifdef TINY_SEQ_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] RUN_LAST = CW'(TIMEOUT - 1);
   logic [CW-1:0]  runCnt_q;
   logic           err_q;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // Load slots 0..3 and read slots 0..9 share this address list.
   function automatic logic [5:0] listAddr(input logic [3:0] k);
      case (k)
         4'd0:    return 6'd3;
         4'd1:    return 6'd5;
         4'd2:    return 6'd6;
         4'd3:    return 6'd7;
         4'd4:    return 6'd9;
         4'd5:    return 6'd10;
         4'd6:    return 6'd11;
         4'd7:    return 6'd12;
         4'd8:    return 6'd13;
         default: return 6'd14;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         lat_q      <= '0;
         doneSeen_q <= 1'b0;
         op1_q      <= '0;
         op2_q      <= '0;
         op3_q      <= '0;
         busy_q     <= 1'b0;
         resValid_q <= 1'b0;
         resLast_q  <= 1'b0;
         resAddr_q  <= '0;
         resData_q  <= '0;
         tReset_q   <= 1'b1;
         tSel_q     <= 1'b0;
         tW_q       <= 1'b0;
         tAddr_q    <= '0;
         tData_q    <= '0;
`ifdef TINY_SEQ_TIMEOUT_EN
         runCnt_q   <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         // Previous-cycle done, so RUN reacts only to a fresh rising edge.
         doneSeen_q <= t_done;
         case (state_q)
            IDLE: begin
               if (start) begin
                  tData_q  <= xp;
                  op1_q    <= yp;
                  op2_q    <= xq;
                  op3_q    <= yq;
                  tAddr_q  <= listAddr(4'd0);
                  tSel_q   <= 1'b1;
                  tW_q     <= 1'b1;
                  tReset_q <= 1'b1;
                  busy_q   <= 1'b1;
                  idx_q    <= '0;
`ifdef TINY_SEQ_TIMEOUT_EN
                  err_q    <= 1'b0;
`endif
                  state_q  <= LOAD;
               end
            end
            LOAD: begin
               if (idx_q == 4'd3) begin
                  tSel_q   <= 1'b0;
                  tW_q     <= 1'b0;
                  tReset_q <= 1'b0;
`ifdef TINY_SEQ_TIMEOUT_EN
                  runCnt_q <= '0;
`endif
                  state_q  <= RUN;
               end else begin
                  idx_q   <= idx_q + 4'd1;
                  tAddr_q <= listAddr(idx_q + 4'd1);
                  tData_q <= op1_q;
                  op1_q   <= op2_q;
                  op2_q   <= op3_q;
               end
            end
            RUN: begin
               if (!doneSeen_q && t_done) begin
                  idx_q   <= '0;
                  lat_q   <= '0;
                  tSel_q  <= 1'b1;
                  tAddr_q <= listAddr(4'd0);
                  state_q <= READ;
               end
`ifdef TINY_SEQ_TIMEOUT_EN
               else if (runCnt_q == RUN_LAST) begin
                  err_q    <= 1'b1;
                  busy_q   <= 1'b0;
                  tReset_q <= 1'b1;
                  state_q  <= IDLE;
               end else begin
                  runCnt_q <= runCnt_q + CW'(1);
               end
`endif
            end
            READ: begin
               if (lat_q == LAT_LAST) begin
                  resData_q  <= t_out;
                  resAddr_q  <= tAddr_q;
                  resLast_q  <= (idx_q == 4'd9);
                  resValid_q <= 1'b1;
                  state_q    <= PUSH;
               end else begin
                  lat_q <= lat_q + LW'(1);
               end
            end
            PUSH: begin
               // Address stays on the core while stalled so nothing is re-read.
               if (res_ready) begin
                  resValid_q <= 1'b0;
                  if (idx_q == 4'd9) begin
                     tSel_q   <= 1'b0;
                     tReset_q <= 1'b1;
                     busy_q   <= 1'b0;
                     state_q  <= IDLE;
                  end else begin
                     idx_q   <= idx_q + 4'd1;
                     tAddr_q <= listAddr(idx_q + 4'd1);
                     lat_q   <= '0;
                     state_q <= READ;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = busy_q;
   assign res_valid = resValid_q;
   assign res_addr  = resAddr_q;
   assign res_data  = resData_q;
   assign res_last  = resLast_q;
   assign t_reset   = tReset_q;
   assign t_sel     = tSel_q;
   assign t_w       = tW_q;
   assign t_addr    = tAddr_q;
   assign t_data    = tData_q;

endmodule
